// File: rtl/key_sched_ctrl.sv
// Purpose: AES key-schedule sequencer; drives the expander and presents round keys 0..NR or NR..0.
// Latency: first round key valid 2 cycles after start (encrypt), NR+2 cycles after (decrypt).
// Backpressure: rk_ready low freezes the expander (done2) and holds rk_round; optional abort via KEY_SCHED_ABORT_EN.
module key_sched_ctrl #(
    parameter int K = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       decrypt,
`ifdef KEY_SCHED_ABORT_EN
    input  logic       abort,
`endif
    input  logic       rk_ready,
    output logic       busy,
    output logic       exp_reset,
    output logic       done1,
    output logic       done2,
    output logic       rk_valid,
    output logic [3:0] rk_round,
    output logic       rk_last,
    output logic       sched_done
);

    localparam logic [3:0] NR = (K == 256) ? 4'd14 : (K == 192) ? 4'd12 : 4'd10;

    typedef enum logic [1:0] {IDLE, LOAD, FWD, REV} state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       dec_q, dec_d;
    logic       sd_q, sd_d;
    logic       hs;

    // Output decode: everything except done2 depends only on state, mode and round.
    always_comb begin
        busy      = (state_q != IDLE);
        exp_reset = (state_q == LOAD);
        done1     = (state_q == REV);
        rk_valid  = ((state_q == FWD) && !dec_q) || (state_q == REV);
        if (state_q == IDLE) begin
            done2 = 1'b1;
        end else if (rk_valid) begin
            done2 = !rk_ready;
        end else begin
            done2 = 1'b0;
        end
        rk_round   = round_q;
        rk_last    = rk_valid && (dec_q ? (round_q == 4'd0) : (round_q == NR));
        sched_done = sd_q;
        hs         = rk_valid && rk_ready;
    end

    // Next-state logic: decrypt runs the expander forward unseen, then walks back with handshakes.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        dec_d   = dec_q;
        sd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dec_d   = decrypt;
                    round_d = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                round_d = 4'd0;
                state_d = FWD;
            end
            FWD: begin
                if (dec_q) begin
                    if (round_q == NR - 4'd1) begin
                        round_d = NR;
                        state_d = REV;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else if (hs) begin
                    if (round_q == NR) begin
                        round_d = 4'd0;
                        sd_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            REV: begin
                if (hs) begin
                    if (round_q == 4'd0) begin
                        sd_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: begin
                round_d = 4'd0;
                state_d = IDLE;
            end
        endcase
`ifdef KEY_SCHED_ABORT_EN
        // Abort wins over any handshake completing in the same cycle.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            round_d = 4'd0;
            sd_d    = 1'b0;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            dec_q   <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            sd_q    <= sd_d;
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Purpose: directed self-checking bench for key_sched_ctrl at K=128/192/256.
// Latency: checks each cycle's outputs at the falling edge.
// Backpressure: exercises rk_ready stalls and ready-while-invalid.
module tb_key_sched_ctrl;

    logic clk, reset, start, decrypt, rk_ready;
`ifdef KEY_SCHED_ABORT_EN
    logic abort;
`endif

    logic       busy_a, er_a, d1_a, d2_a, v_a, l_a, sd_a;
    logic [3:0] r_a;
    logic       busy_b, er_b, d1_b, d2_b, v_b, l_b, sd_b;
    logic [3:0] r_b;
    logic       busy_c, er_c, d1_c, d2_c, v_c, l_c, sd_c;
    logic [3:0] r_c;

    logic [10:0] o128, o192, o256;
    assign o128 = {busy_a, er_a, d1_a, d2_a, v_a, l_a, sd_a, r_a};
    assign o192 = {busy_b, er_b, d1_b, d2_b, v_b, l_b, sd_b, r_b};
    assign o256 = {busy_c, er_c, d1_c, d2_c, v_c, l_c, sd_c, r_c};

    key_sched_ctrl #(.K(128)) dut128 (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt),
`ifdef KEY_SCHED_ABORT_EN
        .abort(abort),
`endif
        .rk_ready(rk_ready), .busy(busy_a), .exp_reset(er_a), .done1(d1_a), .done2(d2_a),
        .rk_valid(v_a), .rk_round(r_a), .rk_last(l_a), .sched_done(sd_a));

    key_sched_ctrl #(.K(192)) dut192 (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt),
`ifdef KEY_SCHED_ABORT_EN
        .abort(abort),
`endif
        .rk_ready(rk_ready), .busy(busy_b), .exp_reset(er_b), .done1(d1_b), .done2(d2_b),
        .rk_valid(v_b), .rk_round(r_b), .rk_last(l_b), .sched_done(sd_b));

    key_sched_ctrl #(.K(256)) dut256 (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt),
`ifdef KEY_SCHED_ABORT_EN
        .abort(abort),
`endif
        .rk_ready(rk_ready), .busy(busy_c), .exp_reset(er_c), .done1(d1_c), .done2(d2_c),
        .rk_valid(v_c), .rk_round(r_c), .rk_last(l_c), .sched_done(sd_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, dec, rdy;
        logic       busy, er, d1, d2, v, l, sd;
        logic [3:0] round;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Idle output pattern: only done2 high.
    localparam logic [10:0] IDLE_O = 11'b000_1000_0000;

    function automatic vec_t mk(input logic st, dec, rdy, busy, er, d1, d2, v, l, sd,
                                input logic [3:0] r);
        vec_t x;
        x.start = st; x.dec = dec; x.rdy = rdy;
        x.busy = busy; x.er = er; x.d1 = d1; x.d2 = d2; x.v = v; x.l = l; x.sd = sd;
        x.round = r;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b0; start = 1'b0; decrypt = 1'b0; rk_ready = 1'b0;
`ifdef KEY_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        // K=128 encrypt then decrypt, cycle by cycle.
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4'd0));
        for (int r = 0; r <= 10; r++)
            tbl.push_back(mk(r == 3, 0, 1, 1, 0, 0, 0, 1, r == 10, 0, 4'(r)));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 4'd0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4'd0));
        for (int r = 0; r <= 9; r++)
            tbl.push_back(mk(0, 0, 1'(r % 2), 1, 0, 0, 0, 0, 0, 0, 4'(r)));
        for (int r = 10; r >= 0; r--)
            tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, r == 0, 0, 4'(r)));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 4'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'd0));

        // Reset state on every instance.
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_128", {21'd0, o128}, {21'd0, IDLE_O});
        chk("reset_192", {21'd0, o192}, {21'd0, IDLE_O});
        chk("reset_256", {21'd0, o256}, {21'd0, IDLE_O});
        next_cycle();
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; decrypt = tbl[i].dec; rk_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {21'd0, o128},
                {21'd0, tbl[i].busy, tbl[i].er, tbl[i].d1, tbl[i].d2, tbl[i].v,
                 tbl[i].l, tbl[i].sd, tbl[i].round});
            next_cycle();
        end

        // K=192 encrypt with a 5-cycle stall at round 3.
        do_reset();
        start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle(); next_cycle(); next_cycle();
        rk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_round%0d", i), {28'd0, r_b}, 32'd3);
            chk($sformatf("stall_done2_%0d", i), {31'd0, d2_b}, 32'd1);
            next_cycle();
        end
        rk_ready = 1'b1;
        @(negedge clk);
        chk("resume_round", {28'd0, r_b}, 32'd3);
        chk("resume_done2", {31'd0, d2_b}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("after_resume_round", {28'd0, r_b}, 32'd4);
        next_cycle();

        // K=256 decrypt: first key at t+16, restart at t+5 ignored.
        do_reset();
        start = 1'b1; decrypt = 1'b1; rk_ready = 1'b1;
        next_cycle();
        for (int i = 1; i <= 15; i++) begin
            start = (i == 5); decrypt = 1'b0;
            @(negedge clk);
            chk($sformatf("k256_novalid_t%0d", i), {31'd0, v_c}, 32'd0);
            next_cycle();
        end
        start = 1'b0;
        @(negedge clk);
        chk("k256_first", {21'd0, o256}, {21'd0, 11'b101_0100_1110});
        next_cycle();

        // K=128 decrypt, reset asserted at REV round 6.
        do_reset();
        start = 1'b1; decrypt = 1'b1; rk_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (d1_a && r_a == 4'd6) found = 1'b1;
            else next_cycle();
        end
        chk("rev6_reached", {31'd0, found}, 32'd1);
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_idle", {21'd0, o128}, {21'd0, IDLE_O});
        next_cycle();
        @(negedge clk);
        chk("midreset_nodone", {31'd0, sd_a}, 32'd0);
        next_cycle();

        // Start accepted in the first cycle after reset release.
        reset = 1'b0;
        next_cycle();
        reset = 1'b1; start = 1'b1; decrypt = 1'b0;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("release_start_load", {31'd0, er_a}, 32'd1);
        next_cycle();

`ifdef KEY_SCHED_ABORT_EN
        // Abort beats the handshake at FWD round 2.
        do_reset();
        start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle(); next_cycle(); next_cycle();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_at_round", {28'd0, r_a}, 32'd2);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", {21'd0, o128}, {21'd0, IDLE_O});
        next_cycle();
        @(negedge clk);
        chk("abort_nodone", {31'd0, sd_a}, 32'd0);
        next_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
